// File: rtl/mod_arith_pkg.sv
// Shared encodings and constants for the runtime-modulus arithmetic unit.
package mod_arith_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_SQR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_ITER  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    function automatic logic is_addsub(input op_t o);
        return (o == OP_ADD) || (o == OP_SUB);
    endfunction

endpackage

// File: rtl/mod_addsub.sv
// Combinational x+y mod m or x-y mod m; both operands must already be below m,
// so one conditional correction is enough.
module mod_addsub #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_m,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_r
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_add_r;
    logic [WIDTH-1:0] w_sub_r;

    assign w_sum   = {1'b0, i_x} + {1'b0, i_y};
    assign w_add_r = (w_sum >= {1'b0, i_m}) ? WIDTH'(w_sum - {1'b0, i_m}) : w_sum[WIDTH-1:0];

    // x-y+m lands below m, so wrapping in WIDTH bits gives the exact value.
    assign w_sub_r = (i_x >= i_y) ? (i_x - i_y) : (i_x - i_y + i_m);

    assign o_r = i_sub ? w_sub_r : w_add_r;

endmodule

// File: rtl/mod_mul_gen.sv
// Multi-mode modular arithmetic unit (MUL/SQR/ADD/SUB mod a runtime m) with
// valid/ready on both sides; multiplies bit-serially, MSB first.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// CHECK | validate operands, finish ADD/SUB, seed the multiply
// ITER  | one double-and-add step per cycle over b, MSB first
// DONE  | result held until out_ready
module mod_mul_gen
    import mod_arith_pkg::*;
#(
    parameter int               WIDTH     = 256,
    parameter logic [WIDTH-1:0] DEFAULT_M = WIDTH'(SECP256K1_P)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             use_default,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             err
);

    localparam int IW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    op_t              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_r;
    logic [IW-1:0]    r_idx;
    logic             r_err;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_handshake;
    logic             w_last;
    logic             w_bad;
    logic [WIDTH-1:0] w_chk;
    logic [WIDTH-1:0] w_dbl;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_step;

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = r_out_valid;
    assign r           = r_r;
    assign err         = r_err;

    assign w_accept    = in_valid & in_ready;
    assign w_handshake = r_out_valid & out_ready;
    assign w_last      = (r_idx == '0);
    assign w_bad       = (r_m < WIDTH'(2)) || (r_a >= r_m) ||
                         ((r_op != OP_SQR) && (r_b >= r_m));

    mod_addsub #(.WIDTH(WIDTH)) u_chk (
        .i_x   (r_a),
        .i_y   (r_b),
        .i_m   (r_m),
        .i_sub (r_op == OP_SUB),
        .o_r   (w_chk)
    );

    mod_addsub #(.WIDTH(WIDTH)) u_dbl (
        .i_x   (r_acc),
        .i_y   (r_acc),
        .i_m   (r_m),
        .i_sub (1'b0),
        .o_r   (w_dbl)
    );

    mod_addsub #(.WIDTH(WIDTH)) u_add (
        .i_x   (w_dbl),
        .i_y   (r_a),
        .i_m   (r_m),
        .i_sub (1'b0),
        .o_r   (w_add)
    );

    assign w_step = r_b[r_idx] ? w_add : w_dbl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_CHECK;
            ST_CHECK: w_state_nxt = (w_bad || is_addsub(r_op)) ? ST_DONE : ST_ITER;
            ST_ITER:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:  if (w_handshake) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= OP_MUL;
            r_a         <= '0;
            r_b         <= '0;
            r_m         <= '0;
            r_acc       <= '0;
            r_r         <= '0;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op <= op_t'(op);
                        r_a  <= a;
                        r_b  <= (op_t'(op) == OP_SQR) ? a : b;
                        r_m  <= use_default ? DEFAULT_M : m;
                    end
                end
                ST_CHECK: begin
                    if (w_bad) begin
                        r_r   <= '0;
                        r_err <= 1'b1;
                    end else if (is_addsub(r_op)) begin
                        r_r   <= w_chk;
                        r_err <= 1'b0;
                    end else begin
                        r_acc <= '0;
                        r_idx <= IW'(WIDTH - 1);
                    end
                end
                ST_ITER: begin
                    r_acc <= w_step;
                    if (w_last) begin
                        r_r   <= w_step;
                        r_err <= 1'b0;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                ST_DONE: begin
                    // out_valid rises one cycle after DONE is entered, so the
                    // result is always presented from settled flops.
                    r_out_valid <= !w_handshake;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul_gen.sv
// Directed and randomized checks of mod_mul_gen at WIDTH=256 and WIDTH=8.
module tb_mod_mul_gen;

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    logic clk;
    logic rst_n;

    logic         in_valid_w, in_ready_w, use_def_w, out_valid_w, out_ready_w, err_w;
    logic [1:0]   op_w;
    logic [255:0] a_w, b_w, m_w, r_w;

    logic         in_valid_n, in_ready_n, use_def_n, out_valid_n, out_ready_n, err_n;
    logic [1:0]   op_n;
    logic [7:0]   a_n, b_n, m_n, r_n;

    int n_chk = 0;
    int n_err = 0;

    mod_mul_gen u_dut_w (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid_w),
        .in_ready    (in_ready_w),
        .op          (op_w),
        .use_default (use_def_w),
        .a           (a_w),
        .b           (b_w),
        .m           (m_w),
        .out_valid   (out_valid_w),
        .out_ready   (out_ready_w),
        .r           (r_w),
        .err         (err_w)
    );

    mod_mul_gen #(.WIDTH(8), .DEFAULT_M(8'd251)) u_dut_n (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid_n),
        .in_ready    (in_ready_n),
        .op          (op_n),
        .use_default (use_def_n),
        .a           (a_n),
        .b           (b_n),
        .m           (m_n),
        .out_valid   (out_valid_n),
        .out_ready   (out_ready_n),
        .r           (r_n),
        .err         (err_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model(input logic [1:0] o, input logic [255:0] x, input logic [255:0] y,
                         input logic [255:0] mm, output logic [255:0] rr, output logic ee);
        logic [511:0] prod;
        logic [256:0] s;
        if (mm < 2 || x >= mm || (o != 2'b01 && y >= mm)) begin
            rr = '0;
            ee = 1'b1;
        end else begin
            ee = 1'b0;
            case (o)
                2'b00: begin
                    prod = {256'b0, x} * {256'b0, y};
                    rr   = 256'(prod % {256'b0, mm});
                end
                2'b01: begin
                    prod = {256'b0, x} * {256'b0, x};
                    rr   = 256'(prod % {256'b0, mm});
                end
                2'b10: begin
                    s  = {1'b0, x} + {1'b0, y};
                    rr = 256'(s % {1'b0, mm});
                end
                default: begin
                    s  = {1'b0, x} + {1'b0, mm} - {1'b0, y};
                    rr = 256'(s % {1'b0, mm});
                end
            endcase
        end
    endtask

    task automatic run_w(input string tag, input logic [1:0] op_i, input logic ud,
                         input logic [255:0] ai, input logic [255:0] bi, input logic [255:0] mi,
                         input logic [255:0] exp_r, input logic exp_e, input int exp_lat,
                         input bit rnd_rdy);
        int n;
        n = 0;
        while (!in_ready_w && n < 1000) begin @(negedge clk); n++; end
        chk_eq({tag, "/in_ready"}, 256'(in_ready_w), 256'(1));
        op_w = op_i; use_def_w = ud; a_w = ai; b_w = bi; m_w = mi; in_valid_w = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_w = 1'b0; op_w = ~op_i; a_w = ~ai; b_w = ~bi; m_w = ~mi;
        n = 0;
        while (!out_valid_w && n < exp_lat + 20) begin
            if (rnd_rdy) out_ready_w = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        out_ready_w = 1'b0;
        chk_eq({tag, "/latency"}, 256'(n), 256'(exp_lat));
        chk_eq({tag, "/r"}, r_w, exp_r);
        chk_eq({tag, "/err"}, 256'(err_w), 256'(exp_e));
        if (rnd_rdy) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk_eq({tag, "/r_held"}, r_w, exp_r);
        end
        out_ready_w = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_w = 1'b0;
        chk_eq({tag, "/out_valid_drop"}, 256'(out_valid_w), 256'(0));
        chk_eq({tag, "/in_ready_back"}, 256'(in_ready_w), 256'(1));
    endtask

    task automatic run_n(input string tag, input logic [1:0] op_i, input logic ud,
                         input logic [7:0] ai, input logic [7:0] bi, input logic [7:0] mi,
                         input logic [7:0] exp_r, input logic exp_e, input int exp_lat);
        int n;
        n = 0;
        while (!in_ready_n && n < 100) begin @(negedge clk); n++; end
        op_n = op_i; use_def_n = ud; a_n = ai; b_n = bi; m_n = mi; in_valid_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_n = 1'b0; a_n = ~ai; b_n = ~bi; m_n = ~mi;
        n = 0;
        while (!out_valid_n && n < exp_lat + 20) begin @(negedge clk); n++; end
        chk_eq({tag, "/latency"}, 256'(n), 256'(exp_lat));
        chk_eq({tag, "/r"}, 256'(r_n), 256'(exp_r));
        chk_eq({tag, "/err"}, 256'(err_n), 256'(exp_e));
        out_ready_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_n = 1'b0;
        chk_eq({tag, "/in_ready_back"}, 256'(in_ready_n), 256'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] dir_a [6];
        logic [255:0] dir_b [6];
        logic [255:0] dir_e [6];
        logic [255:0] mm, x, y, er;
        logic         ee, ud;
        logic [1:0]   o;
        int           sel, lat, n, seen;

        rst_n = 1'b0;
        in_valid_w = 0; use_def_w = 0; out_ready_w = 0; op_w = 0; a_w = 0; b_w = 0; m_w = 0;
        in_valid_n = 0; use_def_n = 0; out_ready_n = 0; op_n = 0; a_n = 0; b_n = 0; m_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("reset/in_ready", 256'(in_ready_w), 256'(1));
        chk_eq("reset/out_valid", 256'(out_valid_w), 256'(0));
        chk_eq("reset/r", r_w, 256'(0));
        chk_eq("reset/err", 256'(err_w), 256'(0));
        chk_eq("reset/in_ready_n", 256'(in_ready_n), 256'(1));

        dir_a[0] = 0;       dir_b[0] = 0;       dir_e[0] = 0;
        dir_a[1] = 1;       dir_b[1] = 1;       dir_e[1] = 1;
        dir_a[2] = 2;       dir_b[2] = 3;       dir_e[2] = 6;
        dir_a[3] = P - 1;   dir_b[3] = 2;       dir_e[3] = P - 2;
        dir_a[4] = P - 2;   dir_b[4] = P - 3;   dir_e[4] = 6;
        dir_a[5] = 'h12345; dir_b[5] = 'hFED;   dir_e[5] = 'h121EB1E1;
        for (int t = 0; t < 6; t++)
            run_w($sformatf("mul256_%0d", t), 2'b00, 1'b1, dir_a[t], dir_b[t], 256'(0),
                  dir_e[t], 1'b0, 258, 1'b0);

        run_n("add_250_250",  2'b10, 1'b0, 8'd250, 8'd250, 8'd251, 8'd249, 1'b0, 2);
        run_n("sub_3_5",      2'b11, 1'b0, 8'd3,   8'd5,   8'd251, 8'd249, 1'b0, 2);
        run_n("sub_7_7",      2'b11, 1'b0, 8'd7,   8'd7,   8'd251, 8'd0,   1'b0, 2);
        run_n("sqr_250",      2'b01, 1'b0, 8'd250, 8'hFF,  8'd251, 8'd1,   1'b0, 10);
        run_n("mul_17_15",    2'b00, 1'b0, 8'd17,  8'd15,  8'd251, 8'd4,   1'b0, 10);
        run_n("mul_250_250",  2'b00, 1'b0, 8'd250, 8'd250, 8'd251, 8'd1,   1'b0, 10);
        run_n("sqr_5_bff",    2'b01, 1'b0, 8'd5,   8'hFF,  8'd251, 8'd25,  1'b0, 10);
        run_n("add_default",  2'b10, 1'b1, 8'd250, 8'd250, 8'd0,   8'd249, 1'b0, 2);
        run_n("err_m1",       2'b10, 1'b0, 8'd0,   8'd0,   8'd1,   8'd0,   1'b1, 2);
        run_n("err_m0",       2'b00, 1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   1'b1, 2);
        run_n("err_a_eq_m",   2'b00, 1'b0, 8'd251, 8'd1,   8'd251, 8'd0,   1'b1, 2);
        run_n("err_b_ge_m",   2'b10, 1'b0, 8'd1,   8'hFF,  8'd251, 8'd0,   1'b1, 2);

        // Backpressure: the second request stays asserted through the held result.
        op_n = 2'b10; use_def_n = 1'b0; a_n = 8'd1; b_n = 8'd1; m_n = 8'd251; in_valid_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_n = 8'd3; b_n = 8'd4;
        n = 0;
        while (!out_valid_n && n < 20) begin @(negedge clk); n++; end
        chk_eq("bp/latency", 256'(n), 256'(2));
        for (int t = 0; t < 20; t++) begin
            chk_eq($sformatf("bp/r_%0d", t), 256'(r_n), 256'(2));
            chk_eq($sformatf("bp/err_%0d", t), 256'(err_n), 256'(0));
            chk_eq($sformatf("bp/in_ready_%0d", t), 256'(in_ready_n), 256'(0));
            chk_eq($sformatf("bp/out_valid_%0d", t), 256'(out_valid_n), 256'(1));
            @(negedge clk);
        end
        out_ready_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_n = 1'b0;
        chk_eq("bp/in_ready_after", 256'(in_ready_n), 256'(1));
        chk_eq("bp/out_valid_after", 256'(out_valid_n), 256'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid_n = 1'b0;
        n = 0;
        while (!out_valid_n && n < 20) begin @(negedge clk); n++; end
        chk_eq("bp2/latency", 256'(n), 256'(2));
        chk_eq("bp2/r", 256'(r_n), 256'(7));
        out_ready_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_n = 1'b0;

        // Reset in the middle of a multiply.
        op_w = 2'b00; use_def_w = 1'b1; a_w = P - 2; b_w = P - 3; in_valid_w = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_w = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int t = 0; t < 300; t++) begin
            if (out_valid_w) seen++;
            @(negedge clk);
        end
        chk_eq("rst/out_valid_cycles", 256'(seen), 256'(0));
        chk_eq("rst/in_ready", 256'(in_ready_w), 256'(1));
        run_w("rst/mul_2_3", 2'b00, 1'b1, 256'(2), 256'(3), 256'(0), 256'(6), 1'b0, 258, 1'b0);

        for (int t = 0; t < 60; t++) begin
            sel = int'($urandom_range(0, 3));
            mm  = rnd256();
            case (sel)
                0:       mm[0] = 1'b1;
                1:       mm[0] = 1'b0;
                2:       mm = mm >> $urandom_range(200, 255);
                default: mm = P;
            endcase
            ud = (sel == 3);
            x  = (mm != 0) ? rnd256() % mm : rnd256();
            y  = (mm != 0) ? rnd256() % mm : rnd256();
            if ($urandom_range(0, 15) == 0) x = rnd256();
            if ($urandom_range(0, 15) == 0) y = rnd256();
            o = 2'($urandom_range(0, 3));
            model(o, x, y, mm, er, ee);
            lat = (ee || o[1]) ? 2 : 258;
            run_w($sformatf("rnd%0d", t), o, ud, x, y, ud ? rnd256() : mm, er, ee, lat, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
